fall_detector_filtered: RTL and testbench

- Sequential, parametrised successor to the combinational fall detector.
- Compares each valid sensor sample against the factory threshold and requires HOLD consecutive exceeding samples before raising a fall alarm.
- Applies hysteresis on release, latches the alarm until acknowledged, and counts fall events.
- Sits between the accelerometer sample path and the alert/reporting logic.

---
 rtl/fall_detector_filtered.sv | 120 ++++++++++++
 tb/tb_fall_detector_filtered.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fall_detector_filtered.sv
// Filtered fall detector: HOLD consecutive valid samples above the factory threshold raise
// a latched alarm. Hysteresis gates re-arming, and a saturating counter records alarm events.
module fall_detector_filtered #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4,
    parameter int HYST  = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensorValid,
    input  logic [WIDTH-1:0] fdSensorValue,
    input  logic [WIDTH-1:0] fdFactoryValue,
    input  logic             ack,
    output logic             fallDetected,
    output logic             fallPulse,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] fallCount
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMING   = 2'd1,
        ALARM    = 2'd2,
        COOLDOWN = 2'd3
    } stateT;

    localparam logic [WIDTH:0] HystExt  = (WIDTH+1)'(HYST);
    localparam logic [7:0]     HoldLast = 8'(HOLD - 1);

    stateT          curState, nextState;
    logic [7:0]     holdCnt, holdCntNext;
    logic           enterAlarm;
    logic [WIDTH:0] factoryExt, lowThr;
    logic           isAbove, isLow;

    // The release threshold is computed one bit wider and clamps at zero instead of wrapping.
    always_comb begin
        factoryExt = {1'b0, fdFactoryValue};
        lowThr     = '0;
        if (factoryExt >= HystExt) begin
            lowThr = factoryExt - HystExt;
        end
        isAbove = fdSensorValue > fdFactoryValue;
        isLow   = {1'b0, fdSensorValue} <= lowThr;
    end

    always_comb begin
        nextState   = curState;
        holdCntNext = holdCnt;
        enterAlarm  = 1'b0;
        case (curState)
            IDLE: begin
                holdCntNext = '0;
                if (sensorValid && isAbove) begin
                    if (HOLD == 1) begin
                        nextState  = ALARM;
                        enterAlarm = 1'b1;
                    end else begin
                        nextState   = ARMING;
                        holdCntNext = 8'd1;
                    end
                end
            end
            ARMING: begin
                if (sensorValid) begin
                    if (isAbove) begin
                        if (holdCnt == HoldLast) begin
                            nextState   = ALARM;
                            enterAlarm  = 1'b1;
                            holdCntNext = '0;
                        end else begin
                            holdCntNext = holdCnt + 8'd1;
                        end
                    end else if (isLow) begin
                        nextState   = IDLE;
                        holdCntNext = '0;
                    end
                end
            end
            ALARM: begin
                holdCntNext = '0;
                if (ack) begin
                    nextState = COOLDOWN;
                end
            end
            COOLDOWN: begin
                holdCntNext = '0;
                if (sensorValid && isLow) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState   = IDLE;
                holdCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            curState     <= IDLE;
            holdCnt      <= '0;
            fallDetected <= 1'b0;
            fallPulse    <= 1'b0;
            fallCount    <= '0;
        end else begin
            curState     <= nextState;
            holdCnt      <= holdCntNext;
            fallDetected <= (nextState == ALARM);
            fallPulse    <= enterAlarm;
            if (enterAlarm && (fallCount != '1)) begin
                fallCount <= fallCount + 1'b1;
            end
        end
    end

    assign state = curState;

endmodule

// File: tb/tb_fall_detector_filtered.sv
// Directed bench for fall_detector_filtered: default HOLD=4 build plus a HOLD=1, CNT_W=2 build
// that exercises immediate alarm entry and counter saturation.
module tb_fall_detector_filtered;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensorValid;
    logic [7:0] fdSensorValue;
    logic [7:0] fdFactoryValue;
    logic       ack;

    logic       fallDetected, fallPulse;
    logic [1:0] state;
    logic [7:0] fallCount;

    logic       fallDetected1, fallPulse1;
    logic [1:0] state1;
    logic [1:0] fallCount1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    fall_detector_filtered #(.WIDTH(8), .HOLD(4), .HYST(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sensorValid(sensorValid), .fdSensorValue(fdSensorValue),
        .fdFactoryValue(fdFactoryValue), .ack(ack), .fallDetected(fallDetected),
        .fallPulse(fallPulse), .state(state), .fallCount(fallCount)
    );

    fall_detector_filtered #(.WIDTH(8), .HOLD(1), .HYST(2), .CNT_W(2)) dutHold1 (
        .clk(clk), .rst(rst), .sensorValid(sensorValid), .fdSensorValue(fdSensorValue),
        .fdFactoryValue(fdFactoryValue), .ack(ack), .fallDetected(fallDetected1),
        .fallPulse(fallPulse1), .state(state1), .fallCount(fallCount1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] val, input logic a);
        sensorValid   = v;
        fdSensorValue = val;
        ack           = a;
        @(posedge clk);
        #1;
        sensorValid = 1'b0;
        ack         = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        step(1'b0, 8'd0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic chkMain(input string tag, input logic fd, input logic fp,
                           input logic [1:0] st, input logic [7:0] cnt);
        chk({tag, ".fallDetected"}, 32'(fallDetected), 32'(fd));
        chk({tag, ".fallPulse"},    32'(fallPulse),    32'(fp));
        chk({tag, ".state"},        32'(state),        32'(st));
        chk({tag, ".fallCount"},    32'(fallCount),    32'(cnt));
    endtask

    initial begin
        rst            = 1'b1;
        sensorValid    = 1'b0;
        fdSensorValue  = '0;
        fdFactoryValue = 8'd16;
        ack            = 1'b0;

        // Reset held for two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom));
        end
        rst = 1'b0;
        chkMain("reset", 1'b0, 1'b0, 2'd0, 8'd0);
        chk("reset.h1.state", 32'(state1), 32'd0);
        chk("reset.h1.fallCount", 32'(fallCount1), 32'd0);

        // Four consecutive samples of 17
        step(1'b1, 8'd17, 1'b0);
        chkMain("s17.1", 1'b0, 1'b0, 2'd1, 8'd0);
        step(1'b1, 8'd17, 1'b0);
        step(1'b1, 8'd17, 1'b0);
        chkMain("s17.3", 1'b0, 1'b0, 2'd1, 8'd0);
        step(1'b1, 8'd17, 1'b0);
        chkMain("s17.4", 1'b1, 1'b1, 2'd2, 8'd1);
        step(1'b0, 8'd0, 1'b0);
        chkMain("s17.after", 1'b1, 1'b0, 2'd2, 8'd1);

        // Ack while readings stay high, then sustained high cannot re-alarm
        step(1'b1, 8'd20, 1'b1);
        chkMain("ack", 1'b0, 1'b0, 2'd3, 8'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'd20, 1'b0);
        end
        chkMain("cool.10x20", 1'b0, 1'b0, 2'd3, 8'd1);
        step(1'b1, 8'd15, 1'b0);
        chk("cool.band.state", 32'(state), 32'd3);
        step(1'b1, 8'd14, 1'b0);
        chk("cool.low.state", 32'(state), 32'd0);
        // ack outside ALARM is ignored
        step(1'b1, 8'd20, 1'b1);
        chk("idleAck.state", 32'(state), 32'd1);
        step(1'b1, 8'd20, 1'b0);
        step(1'b1, 8'd20, 1'b0);
        step(1'b1, 8'd20, 1'b0);
        chkMain("alarm2", 1'b1, 1'b1, 2'd2, 8'd2);

        // Reset in the middle of ALARM
        rst = 1'b1;
        step(1'b1, 8'd20, 1'b0);
        rst = 1'b0;
        chkMain("rstAlarm", 1'b0, 1'b0, 2'd0, 8'd0);

        // Gaps and a band sample hold the count
        step(1'b1, 8'd20, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        step(1'b1, 8'd20, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        step(1'b1, 8'd20, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        step(1'b1, 8'd15, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        chkMain("gap.band", 1'b0, 1'b0, 2'd1, 8'd0);
        step(1'b1, 8'd20, 1'b0);
        chkMain("gap.5th", 1'b1, 1'b1, 2'd2, 8'd1);

        // A low sample at lowThr drops back to IDLE
        doReset();
        step(1'b1, 8'd20, 1'b0);
        step(1'b1, 8'd20, 1'b0);
        step(1'b1, 8'd20, 1'b0);
        step(1'b1, 8'd14, 1'b0);
        chkMain("drop14", 1'b0, 1'b0, 2'd0, 8'd0);
        step(1'b1, 8'd20, 1'b0);
        step(1'b1, 8'd20, 1'b0);
        step(1'b1, 8'd20, 1'b0);
        chkMain("drop14.3x20", 1'b0, 1'b0, 2'd1, 8'd0);

        // factory=1: lowThr clamps to 0, only sample 0 re-arms
        fdFactoryValue = 8'd1;
        doReset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'd2, 1'b0);
        end
        chkMain("f1.alarm", 1'b1, 1'b1, 2'd2, 8'd1);
        step(1'b1, 8'd2, 1'b1);
        chk("f1.ack.state", 32'(state), 32'd3);
        step(1'b1, 8'd1, 1'b0);
        chk("f1.band1.state", 32'(state), 32'd3);
        step(1'b1, 8'd0, 1'b0);
        chk("f1.low0.state", 32'(state), 32'd0);

        // HOLD=1 build alarms on one sample; CNT_W=2 counter saturates at 3
        fdFactoryValue = 8'd16;
        doReset();
        step(1'b1, 8'd17, 1'b0);
        chk("h1.fallDetected", 32'(fallDetected1), 32'd1);
        chk("h1.fallPulse", 32'(fallPulse1), 32'd1);
        chk("h1.state", 32'(state1), 32'd2);
        chk("h1.fallCount", 32'(fallCount1), 32'd1);
        chk("h1.main.state", 32'(state), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'd17, 1'b1);
            step(1'b1, 8'd0, 1'b0);
            step(1'b1, 8'd17, 1'b0);
        end
        chk("h1.sat.fallPulse", 32'(fallPulse1), 32'd1);
        chk("h1.sat.fallCount", 32'(fallCount1), 32'd3);
        chk("h1.sat.state", 32'(state1), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
